// File: rtl/wb_pwm_decoder.sv
// Wishbone slave measuring RC-receiver PWM high times in microseconds, per channel.
// Optional PWM_DECODER_PERIOD_EN adds per-channel rising-edge period registers at 0x40+4n.
module wb_pwm_decoder #(
   parameter int CLK_FREQ_HZ = 72_000_000,
   parameter int NUM_CH      = 6,
   parameter int MIN_US      = 800,
   parameter int MAX_US      = 2200,
   parameter int TIMEOUT_US  = 25000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   input  logic              wb_we_i,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              wb_rty_o,
   input  logic [NUM_CH-1:0] pwm_i
);
   // state      | meaning
   // WAIT_RISE  | idle, waiting for a rising edge on the pin
   // HIGH       | pin high, counting microseconds in hi_cnt
   // STUCK      | pin high far too long; channel invalid until it falls

   typedef enum logic [1:0] {S_WAIT_RISE, S_HIGH, S_STUCK} state_t;

   localparam int DIV   = CLK_FREQ_HZ / 1_000_000;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AGE_W = $clog2(TIMEOUT_US + 1);
   localparam logic [15:0] MIN_C   = 16'(MIN_US);
   localparam logic [15:0] MAX_C   = 16'(MAX_US);
   localparam logic [15:0] STUCK_C = 16'(MAX_US + 1000);

   logic [PRE_W-1:0] r_pre;
   logic             w_tick;
   logic [NUM_CH-1:0] r_sync1, r_sync2, r_prev, w_rise, w_fall;
   state_t           r_state [NUM_CH];
   state_t           w_state_nxt [NUM_CH];
   logic [15:0]      r_hi_cnt [NUM_CH];
   logic [15:0]      r_width [NUM_CH];
   logic [7:0]       r_glitch [NUM_CH];
   logic [AGE_W-1:0] r_age [NUM_CH];
   logic [NUM_CH-1:0] r_valid;
   logic [NUM_CH-1:0] w_start, w_count, w_accept, w_reject, w_stuck, w_rise_ev, w_to;
   logic             r_enable, r_ack, r_err;
   logic [31:0]      r_dat;
   logic [5:0]       w_word;
   logic [31:0]      w_rd_data;
   logic [63:0]      w_glitch_all;
   logic             w_mapped, w_ro, w_req, w_bad, w_ctrl_wr, w_glitch_clr;
   logic             w_unused;

   assign w_unused = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:2]};
   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign wb_rty_o = 1'b0;

   assign w_tick = (r_pre == '0);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       r_pre <= PRE_W'(DIV - 1);
      else if (w_tick) r_pre <= PRE_W'(DIV - 1);
      else             r_pre <= r_pre - 1'b1;
   end

   // Synchroniser resets to 1 so a pin already high at reset release is not taken as a rise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_prev  <= '1;
      end else begin
         r_sync1 <= pwm_i;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end
   assign w_rise = r_sync2 & ~r_prev;
   assign w_fall = ~r_sync2 & r_prev;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_CH; i++) r_state[i] <= S_WAIT_RISE;
      end else begin
         for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_state_nxt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         if (!r_enable) w_state_nxt[i] = S_WAIT_RISE;
         else begin
            case (r_state[i])
               S_WAIT_RISE: if (w_rise[i]) w_state_nxt[i] = S_HIGH;
               S_HIGH: begin
                  if (w_fall[i])                   w_state_nxt[i] = S_WAIT_RISE;
                  else if (r_hi_cnt[i] >= STUCK_C) w_state_nxt[i] = S_STUCK;
               end
               S_STUCK:     if (w_fall[i]) w_state_nxt[i] = S_WAIT_RISE;
               default:     w_state_nxt[i] = S_WAIT_RISE;
            endcase
         end
      end
   end

   always_comb begin
      w_start = '0; w_count = '0; w_accept = '0; w_reject = '0;
      w_stuck = '0; w_rise_ev = '0; w_to = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_start[i]   = r_enable && r_state[i] == S_WAIT_RISE && w_rise[i];
         w_count[i]   = r_enable && r_state[i] == S_HIGH && w_tick;
         w_accept[i]  = r_enable && r_state[i] == S_HIGH && w_fall[i]
                        && r_hi_cnt[i] >= MIN_C && r_hi_cnt[i] <= MAX_C;
         w_reject[i]  = r_enable && r_state[i] == S_HIGH && w_fall[i] && !w_accept[i];
         w_stuck[i]   = r_enable && r_state[i] == S_STUCK;
         w_rise_ev[i] = r_enable && w_rise[i];
         w_to[i]      = r_enable && w_tick && !w_rise[i] && r_age[i] == AGE_W'(TIMEOUT_US - 1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_hi_cnt[i] <= '0;
            r_width[i]  <= '0;
            r_glitch[i] <= '0;
            r_age[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_start[i])                             r_hi_cnt[i] <= '0;
            else if (w_count[i] && r_hi_cnt[i] != '1)   r_hi_cnt[i] <= r_hi_cnt[i] + 1'b1;
            if (w_to[i] || w_stuck[i]) begin
               r_width[i] <= '0;
               r_valid[i] <= 1'b0;
            end else if (w_accept[i]) begin
               r_width[i] <= r_hi_cnt[i];
               r_valid[i] <= 1'b1;
            end
            if (w_glitch_clr)                           r_glitch[i] <= '0;
            else if (w_reject[i] && r_glitch[i] != '1)  r_glitch[i] <= r_glitch[i] + 1'b1;
            if (w_rise_ev[i])                           r_age[i] <= '0;
            else if (r_enable && w_tick && r_age[i] != AGE_W'(TIMEOUT_US))
               r_age[i] <= r_age[i] + 1'b1;
         end
      end
   end

`ifdef PWM_DECODER_PERIOD_EN
   logic [15:0]       r_per_cnt [NUM_CH];
   logic [15:0]       r_period [NUM_CH];
   logic [NUM_CH-1:0] r_rise_seen;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rise_seen <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_per_cnt[i] <= '0;
            r_period[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_rise_ev[i]) begin
               if (r_rise_seen[i]) r_period[i] <= r_per_cnt[i];
               r_rise_seen[i] <= 1'b1;
               r_per_cnt[i]   <= '0;
            end else begin
               if (r_enable && w_tick && r_per_cnt[i] != '1) r_per_cnt[i] <= r_per_cnt[i] + 1'b1;
               if (w_to[i]) begin
                  r_period[i]    <= '0;
                  r_rise_seen[i] <= 1'b0;
               end
            end
         end
      end
   end
`endif

   assign w_word = wb_adr_i[7:2];

   always_comb begin
      w_glitch_all = '0;
      for (int i = 0; i < NUM_CH; i++) w_glitch_all[8*i +: 8] = r_glitch[i];
   end

   always_comb begin
      w_rd_data = '0;
      w_mapped  = 1'b0;
      w_ro      = 1'b1;
      if (w_word < 6'd8) begin
         w_mapped = 1'b1;
         for (int i = 0; i < NUM_CH; i++)
            if (w_word == 6'(i)) w_rd_data = {r_valid[i], 15'b0, r_width[i]};
      end
      case (w_word)
         6'd8:  begin w_mapped = 1'b1; w_rd_data[NUM_CH-1:0] = r_valid; end
         6'd9:  begin w_mapped = 1'b1; w_ro = 1'b0; w_rd_data = 32'(r_enable); end
         6'd10: begin w_mapped = 1'b1; w_rd_data = w_glitch_all[31:0]; end
         6'd11: begin w_mapped = 1'b1; w_rd_data = w_glitch_all[63:32]; end
         default: ;
      endcase
`ifdef PWM_DECODER_PERIOD_EN
      if (w_word[5:3] == 3'b010) begin
         w_mapped = 1'b1;
         for (int i = 0; i < NUM_CH; i++)
            if (w_word[2:0] == 3'(i)) w_rd_data = {16'b0, r_period[i]};
      end
`endif
   end

   // A request is only taken while no response is pending, giving one ack every other cycle.
   assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
   assign w_bad        = ~w_mapped | (wb_we_i & w_ro);
   assign w_ctrl_wr    = w_req & ~w_bad & wb_we_i;
   assign w_glitch_clr = w_ctrl_wr & wb_dat_i[1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_dat    <= '0;
         r_enable <= 1'b1;
      end else begin
         r_ack <= w_req & ~w_bad;
         r_err <= w_req & w_bad;
         if (w_req)     r_dat    <= (wb_we_i | w_bad) ? 32'b0 : w_rd_data;
         if (w_ctrl_wr) r_enable <= wb_dat_i[0];
      end
   end
endmodule

// File: tb/tb_wb_pwm_decoder.sv
// Scoreboard bench for wb_pwm_decoder: bus tasks queue expected responses, a monitor checks them.
`timescale 1ns/1ps
module tb_wb_pwm_decoder;
   localparam int NCH = 6;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o, wb_rty_o;
   logic [3:0]  wb_sel_i;
   logic [NCH-1:0] pwm_i;

   int tests = 0;
   int failed = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic        chk;
      int          tol;
      string       name;
   } exp_t;
   exp_t q[$];

   always #125 clk = ~clk;

   // Timeout shortened so the stale-signal case fits a short run.
   wb_pwm_decoder #(.CLK_FREQ_HZ(4_000_000), .NUM_CH(NCH), .MIN_US(800), .MAX_US(2200),
                    .TIMEOUT_US(4000)) dut (
      .clk(clk), .rstn(rstn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .pwm_i(pwm_i)
   );

   always @(negedge clk) begin
      if (rstn && (wb_ack_o || wb_err_o)) begin
         exp_t e;
         logic ok;
         int d;
         tests++;
         if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_response: ack=%0b err=%0b data=%08h, none required",
                     wb_ack_o, wb_err_o, wb_dat_o);
         end else begin
            e  = q.pop_front();
            ok = (wb_err_o == e.err) && (wb_ack_o == !e.err) && (wb_rty_o == 1'b0);
            if (e.chk) begin
               d = int'(wb_dat_o[15:0]) - int'(e.data[15:0]);
               if (d < 0) d = -d;
               ok = ok && (wb_dat_o[31:16] == e.data[31:16]) && (d <= e.tol);
            end
            if (!ok) begin
               failed++;
               $display("FAIL %s: got ack=%0b err=%0b data=%08h, required err=%0b data=%08h (tol %0d)",
                        e.name, wb_ack_o, wb_err_o, wb_dat_o, e.err, e.data, e.tol);
            end
         end
      end
   end

   task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                      input logic [31:0] exp, input logic exp_err, input int tol, input string nm);
      exp_t e;
      logic got;
      e.data = exp; e.err = exp_err; e.chk = !we && !exp_err; e.tol = tol; e.name = nm;
      q.push_back(e);
      @(posedge clk); #1;
      wb_adr_i = {24'b0, adr}; wb_dat_i = wdat; wb_we_i = we;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         if (wb_ack_o || wb_err_o) got = 1'b1;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (!got) begin
         tests++; failed++;
         $display("FAIL %s: no ack/err within 8 cycles, required a response", nm);
         void'(q.pop_back());
      end
   endtask

   task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input int tol, input string nm);
      bus(1'b0, adr, 32'h0, exp, 1'b0, tol, nm);
   endtask
   task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input string nm);
      bus(1'b1, adr, dat, 32'h0, 1'b0, 0, nm);
   endtask
   task automatic acc_err(input logic we, input logic [7:0] adr, input string nm);
      bus(we, adr, 32'h0000_1234, 32'h0, 1'b1, 0, nm);
   endtask
   task automatic hold_us(input int us);
      repeat (us * 4) @(posedge clk);
      #1;
   endtask

   initial begin
      #30_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      failed++;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; pwm_i = '0; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
      wb_sel_i = 4'hF; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      repeat (5) @(posedge clk);
      #1 rstn = 1'b1;
      hold_us(1);

      rd(8'h24, 32'h0000_0001, 0, "ctrl_reset");
      rd(8'h00, 32'h0000_0000, 0, "width0_reset");
      rd(8'h20, 32'h0000_0000, 0, "status_reset");
      rd(8'h28, 32'h0000_0000, 0, "glitch_reset");

      pwm_i[0] = 1'b1; hold_us(1500); pwm_i[0] = 1'b0; hold_us(3);
      rd(8'h00, 32'h8000_05DC, 1, "width0_1500");
      rd(8'h20, 32'h0000_0001, 0, "status_ch0");

      pwm_i[2] = 1'b1; hold_us(300); pwm_i[2] = 1'b0; hold_us(3);
      rd(8'h08, 32'h0000_0000, 0, "width2_short");
      rd(8'h28, 32'h0001_0000, 0, "glitch_ch2");
      wr(8'h24, 32'h0000_0003, "ctrl_clr_glitch");
      rd(8'h28, 32'h0000_0000, 0, "glitch_cleared");
      rd(8'h24, 32'h0000_0001, 0, "ctrl_selfclear");

      acc_err(1'b0, 8'h30, "rd_unmapped_30");
      acc_err(1'b1, 8'h00, "wr_ro_width0");
      rd(8'h00, 32'h8000_05DC, 1, "width0_after_wr");
      acc_err(1'b1, 8'h20, "wr_ro_status");
      rd(8'h18, 32'h0000_0000, 0, "width6_absent");
      rd(8'h1C, 32'h0000_0000, 0, "width7_absent");
`ifndef PWM_DECODER_PERIOD_EN
      acc_err(1'b0, 8'h40, "rd_period_off");
`endif

      pwm_i[1] = 1'b1; hold_us(1200); pwm_i[1] = 1'b0; hold_us(3);
      rd(8'h04, 32'h8000_04B0, 1, "width1_1200");
      rd(8'h20, 32'h0000_0003, 0, "status_ch01");

      pwm_i[3] = 1'b1; hold_us(1000); pwm_i[3] = 1'b0; hold_us(50);
      rd(8'h0C, 32'h8000_03E8, 1, "width3_1000");
      pwm_i[3] = 1'b1; hold_us(3250);
      rd(8'h0C, 32'h0000_0000, 0, "width3_stuck");
      pwm_i[3] = 1'b0; hold_us(3);
      rd(8'h28, 32'h0000_0000, 0, "glitch_after_stuck");
      rd(8'h04, 32'h0000_0000, 0, "width1_timeout");
      rd(8'h20, 32'h0000_0000, 0, "status_timeout");

      wr(8'h24, 32'h0000_0000, "ctrl_disable");
      pwm_i[4] = 1'b1; hold_us(1000); pwm_i[4] = 1'b0; hold_us(3);
      rd(8'h10, 32'h0000_0000, 0, "width4_disabled");
      rd(8'h24, 32'h0000_0000, 0, "ctrl_disabled");
      wr(8'h24, 32'h0000_0001, "ctrl_enable");

      pwm_i[0] = 1'b1; hold_us(200);
      rstn = 1'b0; hold_us(1); rstn = 1'b1; hold_us(1);
      rd(8'h00, 32'h0000_0000, 0, "width0_midreset");
      rd(8'h24, 32'h0000_0001, 0, "ctrl_midreset");
      hold_us(300); pwm_i[0] = 1'b0; hold_us(3);
      rd(8'h00, 32'h0000_0000, 0, "width0_partial");
      rd(8'h28, 32'h0000_0000, 0, "glitch_partial");
      hold_us(10);
      pwm_i[0] = 1'b1; hold_us(1000); pwm_i[0] = 1'b0; hold_us(3);
      rd(8'h00, 32'h8000_03E8, 1, "width0_1000");
      rd(8'h20, 32'h0000_0001, 0, "status_after_reset");
`ifdef PWM_DECODER_PERIOD_EN
      hold_us(1997);
      pwm_i[0] = 1'b1; hold_us(1000); pwm_i[0] = 1'b0; hold_us(3);
      rd(8'h40, 32'h0000_0BB8, 1, "period0_3000");
`endif

      hold_us(2);
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
